// File: rtl/calc_display_pkg.sv
// Shared types and constants for the calculator 7-segment display driver.
package calc_display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV   = 3'd1,
        ST_SHOW_H = 3'd2,
        ST_SHOW_T = 3'd3,
        ST_SHOW_O = 3'd4,
        ST_GAP    = 3'd5
    } disp_state_t;

    // Segment patterns, a..g on bits 0..6, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int BCD_ITERS = 8;

endpackage

// File: rtl/calc_display_driver_seg7_decoder.sv
// BCD digit to 7-segment pattern; non-decimal nibbles render blank.
module seg7_decoder
    import calc_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display_driver.sv
// Shows an 8-bit value in decimal on one 7-segment digit, cycling H/T/O/gap.
// Optional macro CALC_DISP_ZERO_SUPPRESS_EN skips leading-zero digits.
module calc_display_driver
    import calc_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] value,
    input  logic       load,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int              DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [2:0]      ITER_LAST  = 3'(BCD_ITERS - 1);

    disp_state_t   state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [9:0]    bcd_q, bcd_d;
    logic [2:0]    iter_q, iter_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          busy_q, busy_d;

    logic [3:0]    tens_adj_s, ones_adj_s;
    logic [3:0]    digit_s;
    logic          show_s;
    logic [6:0]    dec_seg_s;

    // First digit of the display loop; leading zeros are skipped when suppression is on
    function automatic disp_state_t first_state(input logic [9:0] b);
`ifdef CALC_DISP_ZERO_SUPPRESS_EN
        if (b[9:8] != 2'd0) begin
            return ST_SHOW_H;
        end else if (b[7:4] != 4'd0) begin
            return ST_SHOW_T;
        end else begin
            return ST_SHOW_O;
        end
`else
        if (b[9:8] != 2'd0) begin
            return ST_SHOW_H;
        end else begin
            return ST_SHOW_H;
        end
`endif
    endfunction

    // Double-dabble add-3 correction; hundreds never exceeds 2 so needs none
    always_comb begin
        if (bcd_q[3:0] >= 4'd5) begin
            ones_adj_s = bcd_q[3:0] + 4'd3;
        end else begin
            ones_adj_s = bcd_q[3:0];
        end
        if (bcd_q[7:4] >= 4'd5) begin
            tens_adj_s = bcd_q[7:4] + 4'd3;
        end else begin
            tens_adj_s = bcd_q[7:4];
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        dwell_d = dwell_q;
        if (!ena) begin
            state_d = state_q;
        end else if (load) begin
            shift_d = value;
            bcd_d   = 10'd0;
            iter_d  = 3'd0;
            dwell_d = '0;
            state_d = ST_CONV;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CONV: begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bcd_d   = {bcd_q[8], tens_adj_s, ones_adj_s, shift_q[7]};
                    if (iter_q == ITER_LAST) begin
                        iter_d  = 3'd0;
                        dwell_d = '0;
                        state_d = first_state(bcd_d);
                    end else begin
                        iter_d  = iter_q + 3'd1;
                    end
                end
                ST_SHOW_H, ST_SHOW_T, ST_SHOW_O, ST_GAP: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        case (state_q)
                            ST_SHOW_H: state_d = ST_SHOW_T;
                            ST_SHOW_T: state_d = ST_SHOW_O;
                            ST_SHOW_O: state_d = ST_GAP;
                            default:   state_d = first_state(bcd_q);
                        endcase
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Digit selection uses next-state values so outputs register in step with the FSM
    always_comb begin
        digit_s = 4'd0;
        show_s  = 1'b0;
        case (state_d)
            ST_SHOW_H: begin
                digit_s = {2'b00, bcd_d[9:8]};
                show_s  = 1'b1;
            end
            ST_SHOW_T: begin
                digit_s = bcd_d[7:4];
                show_s  = 1'b1;
            end
            ST_SHOW_O: begin
                digit_s = bcd_d[3:0];
                show_s  = 1'b1;
            end
            default: begin
                digit_s = 4'd0;
                show_s  = 1'b0;
            end
        endcase
    end

    seg7_decoder u_dec (
        .digit (digit_s),
        .seg   (dec_seg_s)
    );

    // Output register next values
    always_comb begin
        seg_d  = seg_q;
        dp_d   = dp_q;
        busy_d = busy_q;
        if (ena) begin
            seg_d  = show_s ? dec_seg_s : SEG_BLANK;
            dp_d   = (state_d == ST_SHOW_O);
            busy_d = (state_d == ST_CONV);
        end else begin
            seg_d  = seg_q;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= 8'd0;
            bcd_q   <= 10'd0;
            iter_q  <= 3'd0;
            dwell_q <= '0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            dwell_q <= dwell_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// Randomized and directed bench for calc_display_driver against a slot-list model.
module tb_calc_display_driver;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       load;
    logic [7:0] value;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: cycles since load, and the list of display slots for the loaded value
    bit         m_active = 1'b0;
    int         m_n      = 0;
    int         m_nslots = 4;
    logic [6:0] m_seg [4];
    logic       m_dp  [4];

    calc_display_driver #(.DWELL_CYCLES(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .value (value),
        .load  (load),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_load(input logic [7:0] v);
        int d [3];
        int first;
        int k;
        d[0] = int'(v) / 100;
        d[1] = (int'(v) / 10) % 10;
        d[2] = int'(v) % 10;
        first = 0;
`ifdef CALC_DISP_ZERO_SUPPRESS_EN
        if (d[0] == 0) first = 1;
        if (d[0] == 0 && d[1] == 0) first = 2;
`endif
        k = 0;
        for (int i = first; i < 3; i++) begin
            m_seg[k] = seg_tab[d[i]];
            m_dp[k]  = (i == 2);
            k++;
        end
        m_seg[k] = 7'h00;
        m_dp[k]  = 1'b0;
        m_nslots = k + 1;
        m_active = 1'b1;
        m_n      = 0;
    endtask

    function automatic logic [8:0] model_out();
        int slot;
        if (!m_active) return 9'h000;
        if (m_n < 8) return 9'h100;
        slot = ((m_n - 8) / DWELL) % m_nslots;
        return {1'b0, m_dp[slot], m_seg[slot]};
    endfunction

    task automatic step(input logic ld, input logic [7:0] v, input logic en, input string tag);
        load  = ld;
        value = v;
        ena   = en;
        @(posedge clk);
        if (en) begin
            if (ld) model_load(v);
            else if (m_active) m_n++;
        end
        #1;
        check_eq(tag, 32'({busy, dp, seg}), 32'(model_out()));
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b1, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        load  = 1'b0;
        value = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", 32'({busy, dp, seg}), 32'd0);
        rst_n = 1'b1;
        run(50, "idle");

        step(1'b1, 8'd173, 1'b1, "ld173");
        run(40, "v173");
        step(1'b1, 8'd255, 1'b1, "ld255");
        run(30, "v255");
        step(1'b1, 8'd0, 1'b1, "ld0");
        run(30, "v0");
        step(1'b1, 8'd7, 1'b1, "ld7");
        run(30, "v7");

        // Reload while the tens digit is showing
        step(1'b1, 8'd173, 1'b1, "ld173b");
        run(13, "v173b");
        step(1'b1, 8'd42, 1'b1, "ld42");
        run(30, "v42");

        // Asynchronous reset in the middle of a conversion
        step(1'b1, 8'd99, 1'b1, "ld99");
        run(3, "conv99");
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", 32'({busy, dp, seg}), 32'd0);
        m_active = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_hold", 32'({busy, dp, seg}), 32'd0);
        rst_n = 1'b1;
        run(10, "post_rst");

        // Freeze during the ones digit
        step(1'b1, 8'd200, 1'b1, "ld200");
        run(17, "v200");
        for (int i = 0; i < 10; i++) step(1'b1, 8'd5, 1'b0, "ena_off");
        run(20, "resume");

        // Random traffic: loads at any point, sporadic enable drops
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
                 "rand");
        end
        run(40, "tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
